// File: rtl/encoder_result_buffer.sv
// Result FIFO behind the 4-bit priority encoder: stamps each valid encoder
// result with a free-running cycle count and serves it first-word-fallthrough.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_q, in_valid       encoder index and its valid strobe
//   out_ready            consumer accepts the head entry this cycle
//   out_valid/q/ts       head entry (q and ts read 0 while empty)
//   count, full, empty   occupancy after the last edge
//   drop_cnt             saturating count of results lost while full
//   hit_cnt              per-index saturating accept counters, index i at
//                        [i*CNT_W +: CNT_W]; present only when
//                        ENC_RESULT_BUF_HIT_CNT_EN is defined
module encoder_result_buffer #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               in_q,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [1:0]               out_q,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
`ifdef ENC_RESULT_BUF_HIT_CNT_EN
    output logic [4*CNT_W-1:0]       hit_cnt,
`endif
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TS_W+1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             push, pop, drop;
    logic [TS_W+1:0]  head;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        pop   = !empty && out_ready;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push  = in_valid && (!full || pop);
        drop  = in_valid && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        ts_d = ts_q + TS_W'(1);

        drop_d = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_q, ts_q};
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = !empty;
        out_q     = empty ? 2'd0 : head[TS_W+:2];
        out_ts    = empty ? '0 : head[TS_W-1:0];
        count     = count_q;
        drop_cnt  = drop_q;
    end

`ifdef ENC_RESULT_BUF_HIT_CNT_EN
    logic [CNT_W-1:0] hit_q [4];
    logic [CNT_W-1:0] hit_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit_d[i] = hit_q[i];
            if (push && (in_q == 2'(i)) && (hit_q[i] != '1)) begin
                hit_d[i] = hit_q[i] + CNT_W'(1);
            end
            hit_cnt[i*CNT_W +: CNT_W] = hit_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                hit_q[i] <= '0;
            end else begin
                hit_q[i] <= hit_d[i];
            end
        end
    end
`endif

endmodule
